// File: rtl/nco_keyer_ctrl.sv
// BPSK keying sequencer: drives NCO clock-enable from a fractional-rate accumulator and
// NCO phase-invert per symbol through preamble, buffered data and tail phases.
module nco_keyer_ctrl #(
  parameter int unsigned ACC_W        = 16,
  parameter int unsigned SYM_CYCLES   = 64,
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned TAIL_LEN     = 4
) (
  input  logic             pll_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] rate_word,
  input  logic             sym_valid,
  input  logic             sym_data,
  output logic             sym_ready,
  output logic             nco_clk_en,
  output logic             nco_pi,
  output logic             busy,
  output logic             underrun
);

  localparam int unsigned CNT_W   = $clog2(SYM_CYCLES);
  localparam int unsigned IDX_MAX = (PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN;
  localparam int unsigned IDX_W   = $clog2(IDX_MAX + 1);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, TAIL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [IDX_W-1:0]   sym_idx_q, sym_idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   rate_q, rate_d;
  logic               hold_valid_q, hold_valid_d;
  logic               hold_bit_q, hold_bit_d;
  logic               stop_pend_q, stop_pend_d;
  logic               nco_pi_d, nco_clk_en_d, underrun_d, busy_d, sym_ready_d;
  logic               boundary, data_bnd;
  logic [ACC_W:0]     acc_sum;

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    sym_idx_d    = sym_idx_q;
    acc_d        = '0;
    rate_d       = rate_q;
    hold_valid_d = hold_valid_q;
    hold_bit_d   = hold_bit_q;
    stop_pend_d  = stop_pend_q;
    nco_pi_d     = nco_pi;
    nco_clk_en_d = 1'b0;
    underrun_d   = underrun;
    data_bnd     = 1'b0;
    acc_sum      = (ACC_W+1)'(acc_q) + (ACC_W+1)'(rate_q);
    boundary     = (state_q != IDLE) && (sym_cnt_q == CNT_W'(SYM_CYCLES - 1));

    if (state_q != IDLE) begin
      sym_cnt_d = boundary ? '0 : sym_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        sym_cnt_d = '0;
        if (start) begin
          state_d     = PREAMBLE;
          rate_d      = rate_word;
          sym_idx_d   = '0;
          underrun_d  = 1'b0;
          stop_pend_d = 1'b0;
          nco_pi_d    = 1'b1;
        end
      end
      PREAMBLE: begin
        if (stop) stop_pend_d = 1'b1;
        if (boundary) begin
          // The last preamble boundary is also the first data boundary
          if (sym_idx_q == IDX_W'(PREAMBLE_LEN - 1)) begin
            state_d  = DATA;
            data_bnd = 1'b1;
          end else begin
            sym_idx_d = sym_idx_q + IDX_W'(1);
            nco_pi_d  = sym_idx_q[0];
          end
        end
      end
      DATA: begin
        if (stop) stop_pend_d = 1'b1;
        data_bnd = boundary;
      end
      TAIL: begin
        if (boundary) begin
          if (sym_idx_q == IDX_W'(TAIL_LEN - 1)) begin
            state_d  = IDLE;
            nco_pi_d = 1'b1;
          end else begin
            sym_idx_d = sym_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (data_bnd) begin
      if (hold_valid_q) begin
        nco_pi_d     = hold_bit_q;
        hold_valid_d = 1'b0;
      end else if (stop_pend_q) begin
        state_d   = TAIL;
        sym_idx_d = '0;
        nco_pi_d  = 1'b1;
      end else begin
        underrun_d = 1'b1;
      end
    end

    // Hold register accepts only when it was empty at the start of the cycle
    if (sym_valid && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_bit_d   = sym_data;
    end

    if ((state_q != IDLE) && (state_d != IDLE)) begin
      acc_d        = acc_sum[ACC_W-1:0];
      nco_clk_en_d = acc_sum[ACC_W];
    end

    busy_d      = (state_d != IDLE);
    sym_ready_d = !hold_valid_d;
  end

  // State and output registers
  always_ff @(posedge pll_clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sym_cnt_q    <= '0;
      sym_idx_q    <= '0;
      acc_q        <= '0;
      rate_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_bit_q   <= 1'b0;
      stop_pend_q  <= 1'b0;
      nco_pi       <= 1'b1;
      nco_clk_en   <= 1'b0;
      underrun     <= 1'b0;
      busy         <= 1'b0;
      sym_ready    <= 1'b1;
    end else begin
      state_q      <= state_d;
      sym_cnt_q    <= sym_cnt_d;
      sym_idx_q    <= sym_idx_d;
      acc_q        <= acc_d;
      rate_q       <= rate_d;
      hold_valid_q <= hold_valid_d;
      hold_bit_q   <= hold_bit_d;
      stop_pend_q  <= stop_pend_d;
      nco_pi       <= nco_pi_d;
      nco_clk_en   <= nco_clk_en_d;
      underrun     <= underrun_d;
      busy         <= busy_d;
      sym_ready    <= sym_ready_d;
    end
  end

endmodule
